csr_access_unit: RTL

//  Executes the CSRRD/CSRWR/CSRXCHG micro-op. It is the stage directly upstream of the Csr register file and the only driver of its write port (WEn/WAddr/WDate).

---
 rtl/csr_access_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/csr_access_unit.sv
// csr_access_unit: runs one CSRRD/CSRWR/CSRXCHG micro-op against the Csr register file.
// Optional feature macro: CSR_RO_FILTER_EN (blocks writes to the read-only CPUID CSR 14'h20).
module csr_access_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
) (
    input  logic              Clk,
    input  logic              Rest,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [1:0]        ReqOp,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqWData,
    input  logic [DATA_W-1:0] ReqMask,
    input  logic              Flush,
    output logic [ADDR_W-1:0] CsrRAddr,
    input  logic [DATA_W-1:0] CsrRData,
    output logic              WEn,
    output logic [ADDR_W-1:0] WAddr,
    output logic [DATA_W-1:0] WDate,
    output logic              RespValid,
    input  logic              RespReady,
    output logic [DATA_W-1:0] RespData,
    output logic              RespIllegal
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_XCHG = 2'b10;
`ifdef CSR_RO_FILTER_EN
    localparam logic [ADDR_W-1:0] CPUID_ADDR = ADDR_W'(14'h20);
`endif

    state_t            state_r;
    logic [1:0]        op_r;
    logic [DATA_W-1:0] wData_r;
    logic [DATA_W-1:0] mask_r;
    logic              isWrite_s;
    logic              roBlock_s;

    function automatic logic [DATA_W-1:0] mergeXchg(
        input logic [DATA_W-1:0] oldVal,
        input logic [DATA_W-1:0] newVal,
        input logic [DATA_W-1:0] mask
    );
        return (oldVal & ~mask) | (newVal & mask);
    endfunction

    // Decode of the latched op; CsrRAddr doubles as the latched CSR address.
    always_comb begin
        isWrite_s = (op_r == OP_WR) || (op_r == OP_XCHG);
`ifdef CSR_RO_FILTER_EN
        roBlock_s = isWrite_s && (CsrRAddr == CPUID_ADDR);
`else
        roBlock_s = 1'b0;
`endif
    end

    // Op sequencer: state plus every registered output.
    always_ff @(posedge Clk) begin
        if (Rest) begin
            state_r     <= IDLE;
            op_r        <= 2'b00;
            wData_r     <= '0;
            mask_r      <= '0;
            ReqReady    <= 1'b1;
            CsrRAddr    <= '0;
            WEn         <= 1'b0;
            WAddr       <= '0;
            WDate       <= '0;
            RespValid   <= 1'b0;
            RespData    <= '0;
            RespIllegal <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ReqValid && !Flush) begin
                        op_r     <= ReqOp;
                        CsrRAddr <= ReqAddr;
                        wData_r  <= ReqWData;
                        mask_r   <= ReqMask;
                        ReqReady <= 1'b0;
                        state_r  <= READ;
                    end
                end
                READ: begin
                    if (Flush) begin
                        ReqReady <= 1'b1;
                        state_r  <= IDLE;
                    end else begin
                        RespData <= CsrRData;
                        if (roBlock_s) begin
                            RespValid   <= 1'b1;
                            RespIllegal <= 1'b1;
                            state_r     <= RESP;
                        end else if (isWrite_s) begin
                            WEn     <= 1'b1;
                            WAddr   <= CsrRAddr;
                            WDate   <= (op_r == OP_XCHG) ? mergeXchg(CsrRData, wData_r, mask_r)
                                                         : wData_r;
                            state_r <= WRITE;
                        end else begin
                            RespValid <= 1'b1;
                            state_r   <= RESP;
                        end
                    end
                end
                WRITE: begin
                    // Flush is deliberately ignored here: the write is already on the bus.
                    WEn       <= 1'b0;
                    RespValid <= 1'b1;
                    state_r   <= RESP;
                end
                RESP: begin
                    if (Flush || RespReady) begin
                        RespValid   <= 1'b0;
                        RespIllegal <= 1'b0;
                        ReqReady    <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    WEn         <= 1'b0;
                    RespValid   <= 1'b0;
                    RespIllegal <= 1'b0;
                    ReqReady    <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule
